// File: rtl/ripple_acc_ctrl_pkg.sv
// Shared types and defaults for the ripple-carry accumulator controller.
// The FSM encoding, the default sizes and the settle-counter width all live here.
package ripple_acc_ctrl_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_SETTLE  = 2'd1,
        STATE_CAPTURE = 2'd2
    } state_e;

    // The counter starts one below the cycle count because the cycle that
    // observes cnt==0 still counts as a settle cycle.
    function automatic logic [CNT_W-1:0] settle_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ripple_acc_ctrl_settle_timer.sv
// Loadable down-counter that measures how long the adder operands have been held.
// o_expired is high whenever the count has reached zero.
module ripple_acc_ctrl_settle_timer
    import ripple_acc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ripple_acc_ctrl.sv
// Clocked start/done wrapper around an external ripple-carry adder: drives the
// operands, waits for the carry chain to settle, then captures into the accumulator.
module ripple_acc_ctrl
    import ripple_acc_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_add_a,
    output logic [WIDTH-1:0] o_add_b,
    output logic             o_add_cin,
    input  logic [WIDTH-1:0] i_add_sum,
    input  logic             i_add_cout,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_carry_flag,
    output logic             o_zero_flag,
    output logic             o_ovf_sticky,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] S_IDLE    = STATE_IDLE;
    localparam logic [1:0] S_SETTLE  = STATE_SETTLE;
    localparam logic [1:0] S_CAPTURE = STATE_CAPTURE;

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $error("ripple_acc_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_cin;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry_flag;
    logic             r_zero_flag;
    logic             r_ovf_sticky;
    logic             r_done;
    logic             w_accept;
    logic             w_expired;

    assign w_accept = (r_state == S_IDLE) && i_start && !i_clear;

    ripple_acc_ctrl_settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (settle_load(SETTLE_CYCLES)),
        .i_dec      (r_state == S_SETTLE),
        .o_expired  (w_expired)
    );

    always_comb begin
        // NOTE: default assignment first so every path drives w_state_nxt and
        // no latch is inferred.
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (i_start) w_state_nxt = S_SETTLE;
                S_SETTLE:  if (w_expired) w_state_nxt = S_CAPTURE;
                S_CAPTURE: w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // clear wins over start and capture; the adder operands are left untouched
    // by clear so an aborted addition leaves its operands visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_cin    <= 1'b0;
            r_acc        <= '0;
            r_carry_flag <= 1'b0;
            r_zero_flag  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (i_clear) begin
                r_acc        <= '0;
                r_carry_flag <= 1'b0;
                r_zero_flag  <= 1'b0;
                r_ovf_sticky <= 1'b0;
            end else if (w_accept) begin
                r_add_a   <= r_acc;
                r_add_b   <= i_op_b;
                r_add_cin <= i_cin;
            end else if (r_state == S_CAPTURE) begin
                r_acc        <= i_add_sum;
                r_carry_flag <= i_add_cout;
                r_zero_flag  <= (i_add_sum == '0);
                r_ovf_sticky <= r_ovf_sticky | i_add_cout;
                r_done       <= 1'b1;
            end
        end
    end

    assign o_add_a      = r_add_a;
    assign o_add_b      = r_add_b;
    assign o_add_cin    = r_add_cin;
    assign o_acc        = r_acc;
    assign o_carry_flag = r_carry_flag;
    assign o_zero_flag  = r_zero_flag;
    assign o_ovf_sticky = r_ovf_sticky;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_ripple_acc_ctrl.sv
// Self-checking bench for ripple_acc_ctrl with behavioural delayed adders and a
// plain-arithmetic accumulator model; a second instance shows the settle constraint.
module tb_ripple_acc_ctrl;

    localparam int ADD_DELAY = 35;   // just under 4 clock periods of 10

    logic clk;
    logic rst;

    logic       start, clear, cin;
    logic [3:0] op_b;
    logic [3:0] add_a, add_b, add_sum, acc;
    logic       add_cin, add_cout, carry_flag, zero_flag, ovf_sticky, busy, done;

    logic       start2, clear2, cin2;
    logic [3:0] op_b2;
    logic [3:0] add_a2, add_b2, add_sum2, acc2;
    logic       add_cin2, add_cout2, carry_flag2, zero_flag2, ovf_sticky2, busy2, done2;

    int vectors;
    int miscompares;

    int m_acc;
    bit m_c, m_z, m_ovf;

    ripple_acc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_clear(clear), .i_op_b(op_b), .i_cin(cin),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
        .i_add_sum(add_sum), .i_add_cout(add_cout),
        .o_acc(acc), .o_carry_flag(carry_flag), .o_zero_flag(zero_flag),
        .o_ovf_sticky(ovf_sticky), .o_busy(busy), .o_done(done)
    );

    ripple_acc_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) dut_short (
        .clk(clk), .rst(rst), .i_start(start2), .i_clear(clear2), .i_op_b(op_b2), .i_cin(cin2),
        .o_add_a(add_a2), .o_add_b(add_b2), .o_add_cin(add_cin2),
        .i_add_sum(add_sum2), .i_add_cout(add_cout2),
        .o_acc(acc2), .o_carry_flag(carry_flag2), .o_zero_flag(zero_flag2),
        .o_ovf_sticky(ovf_sticky2), .o_busy(busy2), .o_done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural adders with a transport delay: every operand change schedules
    // its result ADD_DELAY time units later.
    logic [4:0] q1_val[$];
    longint     q1_t[$];
    logic [4:0] q2_val[$];
    longint     q2_t[$];

    always @(add_a or add_b or add_cin) begin
        q1_val.push_back(5'(int'(add_a) + int'(add_b) + int'(add_cin)));
        q1_t.push_back(longint'($time) + ADD_DELAY);
    end

    always @(add_a2 or add_b2 or add_cin2) begin
        q2_val.push_back(5'(int'(add_a2) + int'(add_b2) + int'(add_cin2)));
        q2_t.push_back(longint'($time) + ADD_DELAY);
    end

    initial begin
        add_sum = '0; add_cout = 1'b0; add_sum2 = '0; add_cout2 = 1'b0;
        forever begin
            #1;
            while (q1_t.size() > 0 && q1_t[0] <= longint'($time)) begin
                {add_cout, add_sum} = q1_val.pop_front();
                void'(q1_t.pop_front());
            end
            while (q2_t.size() > 0 && q2_t[0] <= longint'($time)) begin
                {add_cout2, add_sum2} = q2_val.pop_front();
                void'(q2_t.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input int b, input int c);
        int s;
        s     = m_acc + b + c;
        m_acc = s % 16;
        m_c   = (s >= 16);
        m_z   = (m_acc == 0);
        m_ovf = m_ovf | m_c;
    endtask

    task automatic model_clear();
        m_acc = 0; m_c = 0; m_z = 0; m_ovf = 0;
    endtask

    // Issue one start on the main instance (must be IDLE) and wait for done.
    // Returns with the bench sitting in the done cycle.
    task automatic run_add(input logic [3:0] b, input logic c, output int lat, output int busy_cyc);
        start = 1'b1; op_b = b; cin = c;
        tick();
        start = 1'b0; op_b = 4'($urandom); cin = 1'($urandom);
        lat = 0; busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        model_add(int'(b), int'(c));
    endtask

    task automatic test_reset();
        start = 0; clear = 0; op_b = 0; cin = 0;
        start2 = 0; clear2 = 0; op_b2 = 0; cin2 = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        vectors++;
        if ({acc, carry_flag, zero_flag, ovf_sticky, busy, done} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got acc=%0h cf=%0b zf=%0b ovf=%0b busy=%0b done=%0b expected all 0",
                     acc, carry_flag, zero_flag, ovf_sticky, busy, done);
        end
        vectors++;
        if ({add_a, add_b, add_cin} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_operands: got a=%0h b=%0h cin=%0b expected 0", add_a, add_b, add_cin);
        end
    endtask

    task automatic test_basic_add();
        int lat, bc;
        run_add(4'h5, 1'b0, lat, bc);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        vectors++;
        if (bc !== 4) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
        vectors++;
        if ({acc, carry_flag, zero_flag, ovf_sticky} !== {4'(m_acc), m_c, m_z, m_ovf}) begin
            miscompares++;
            $display("FAIL basic_result: got acc=%0h cf=%0b zf=%0b ovf=%0b expected acc=%0h cf=%0b zf=%0b ovf=%0b",
                     acc, carry_flag, zero_flag, ovf_sticky, m_acc, m_c, m_z, m_ovf);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL done_one_cycle: got done=%0b expected 0", done); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_add(4'hC, 1'b0, lat, bc);
        vectors++;
        if ({acc, carry_flag, ovf_sticky} !== {4'h1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_wrap: got acc=%0h cf=%0b ovf=%0b expected acc=1 cf=1 ovf=1", acc, carry_flag, ovf_sticky);
        end
        tick();
        run_add(4'h1, 1'b0, lat, bc);
        vectors++;
        if ({acc, carry_flag, ovf_sticky} !== {4'h2, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_sticky: got acc=%0h cf=%0b ovf=%0b expected acc=2 cf=0 ovf=1", acc, carry_flag, ovf_sticky);
        end
        tick();
    endtask

    task automatic test_carry_in_zero();
        int lat, bc;
        run_add(4'hD, 1'b0, lat, bc);
        vectors++;
        if (acc !== 4'hF) begin miscompares++; $display("FAIL cin_setup: got acc=%0h expected f", acc); end
        run_add(4'h0, 1'b1, lat, bc);
        vectors++;
        if ({acc, zero_flag, carry_flag} !== {4'h0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL cin_zero: got acc=%0h zf=%0b cf=%0b expected acc=0 zf=1 cf=1", acc, zero_flag, carry_flag);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int ndone;
        start = 1'b1; op_b = 4'h3; cin = 1'b0;
        tick();                          // E0 accepts op_b=3
        op_b = 4'h7; cin = 1'b1;
        tick(); tick();                  // start held across E1 and E2
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            tick();
        end
        model_add(3, 0);
        vectors++;
        if (ndone !== 1) begin miscompares++; $display("FAIL busy_start_ignored: got %0d done pulses expected 1", ndone); end
        vectors++;
        if (acc !== 4'(m_acc)) begin miscompares++; $display("FAIL busy_start_result: got acc=%0h expected %0h", acc, m_acc); end
    endtask

    task automatic test_start_clear();
        int ndone;
        start = 1'b1; clear = 1'b1; op_b = 4'h1;
        tick();
        start = 1'b0; clear = 1'b0;
        model_clear();
        vectors++;
        if ({acc, carry_flag, zero_flag, ovf_sticky, busy} !== 8'd0) begin
            miscompares++;
            $display("FAIL start_clear_idle: got acc=%0h cf=%0b zf=%0b ovf=%0b busy=%0b expected all 0",
                     acc, carry_flag, zero_flag, ovf_sticky, busy);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            tick();
        end
        vectors++;
        if (ndone !== 0) begin miscompares++; $display("FAIL start_clear_no_done: got %0d done pulses expected 0", ndone); end
    endtask

    task automatic test_clear_abort();
        int lat, bc, ndone;
        run_add(4'h6, 1'b0, lat, bc);
        tick();
        start = 1'b1; op_b = 4'h9; cin = 1'b1;
        tick();                          // E0
        start = 1'b0;
        tick();                          // in SETTLE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        vectors++;
        if ({busy, acc, carry_flag, zero_flag, ovf_sticky} !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_abort_state: got busy=%0b acc=%0h cf=%0b zf=%0b ovf=%0b expected all 0",
                     busy, acc, carry_flag, zero_flag, ovf_sticky);
        end
        vectors++;
        if ({add_a, add_b, add_cin} !== {4'h6, 4'h9, 1'b1}) begin
            miscompares++;
            $display("FAIL clear_abort_operands: got a=%0h b=%0h cin=%0b expected a=6 b=9 cin=1", add_a, add_b, add_cin);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            tick();
        end
        vectors++;
        if (ndone !== 0) begin miscompares++; $display("FAIL clear_abort_no_done: got %0d done pulses expected 0", ndone); end
    endtask

    task automatic test_rst_abort();
        int lat, bc;
        run_add(4'h4, 1'b1, lat, bc);
        tick();
        start = 1'b1; op_b = 4'hA; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        vectors++;
        if ({acc, carry_flag, zero_flag, ovf_sticky, busy, done, add_a, add_b, add_cin} !== 19'd0) begin
            miscompares++;
            $display("FAIL rst_abort_outputs: got acc=%0h cf=%0b zf=%0b ovf=%0b busy=%0b done=%0b a=%0h b=%0h cin=%0b expected all 0",
                     acc, carry_flag, zero_flag, ovf_sticky, busy, done, add_a, add_b, add_cin);
        end
        tick(); tick(); tick(); tick();  // let the adder settle on the reset operands
        run_add(4'h3, 1'b0, lat, bc);
        vectors++;
        if (lat !== 4 || acc !== 4'(m_acc)) begin
            miscompares++;
            $display("FAIL rst_abort_restart: got lat=%0d acc=%0h expected lat=4 acc=%0h", lat, acc, m_acc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_add(4'($urandom), 1'($urandom), lat, bc);
            vectors++;
            if (lat !== 4 || bc !== 4 || acc !== 4'(m_acc) || carry_flag !== m_c) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got lat=%0d busy=%0d acc=%0h cf=%0b expected lat=4 busy=4 acc=%0h cf=%0b",
                         i, lat, bc, acc, carry_flag, m_acc, m_c);
            end
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                model_clear();
                vectors++;
                if ({acc, carry_flag, zero_flag, ovf_sticky} !== 7'd0) begin
                    miscompares++;
                    $display("FAIL random_clear[%0d]: got acc=%0h cf=%0b zf=%0b ovf=%0b expected all 0",
                             i, acc, carry_flag, zero_flag, ovf_sticky);
                end
            end else begin
                run_add(4'($urandom), 1'($urandom), lat, bc);
                vectors++;
                if (lat !== 4 || {acc, carry_flag, zero_flag, ovf_sticky} !== {4'(m_acc), m_c, m_z, m_ovf}) begin
                    miscompares++;
                    $display("FAIL random_add[%0d]: got lat=%0d acc=%0h cf=%0b zf=%0b ovf=%0b expected lat=4 acc=%0h cf=%0b zf=%0b ovf=%0b",
                             i, lat, acc, carry_flag, zero_flag, ovf_sticky, m_acc, m_c, m_z, m_ovf);
                end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // One settle cycle against a ~3.5-cycle adder: the capture sees the old sum.
    task automatic test_settle_margin();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            start2 = 1'b1; op_b2 = 4'h5; cin2 = 1'b0;
            tick();
            start2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 20) begin
                tick();
                lat++;
            end
            vectors++;
            if (lat !== 2) begin miscompares++; $display("FAIL short_latency[%0d]: got %0d expected 2", pass, lat); end
            vectors++;
            // First pass: adder still shows 0+0+0 from reset. Second pass: operands
            // 0+5 are unchanged, so the adder has long since settled on 5.
            if (acc2 !== ((pass == 0) ? 4'h0 : 4'h5)) begin
                miscompares++;
                $display("FAIL short_settle_sum[%0d]: got acc=%0h expected %0h", pass, acc2, (pass == 0) ? 4'h0 : 4'h5);
            end
            repeat (4) tick();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        test_reset();
        test_basic_add();
        test_overflow();
        test_carry_in_zero();
        test_ignored_start();
        test_start_clear();
        test_clear_abort();
        test_rst_abort();
        test_back_to_back();
        test_random();
        test_settle_margin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
